rtc_bus_driver: RTL and testbench

Bus-protocol stage directly downstream of the RTC general control FSM. Takes one register-access request (address, read/write, data source) and drives the RTC's multiplexed address/data bus with the address phase, then the data phase. It then returns a single-cycle done flag, which advances the FSM's access counter. Read data is returned together with the register address it came from, for the display/config register bank.

---
 rtl/rtc_bus_driver.sv | 85 ++++++++
 tb/tb_rtc_bus_driver.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_driver.sv
// rtc_bus_driver: drives the RTC multiplexed address/data bus for one register access per request.
module rtc_bus_driver #(
  parameter int T_PHASE = 4,
  parameter int T_GAP   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_en_funcion_rtc,
  input  logic       in_funcion_w_r,
  input  logic       in_flag_inicio,
  input  logic [7:0] in_addr_ram_rtc,
  input  logic [7:0] in_dato_inicio,
  input  logic [7:0] in_dato_escritura,
  input  logic [7:0] in_ad_bus,
  output logic [7:0] out_ad_bus,
  output logic       out_ad_oe,
  output logic       out_cs_n,
  output logic       out_rd_n,
  output logic       out_wr_n,
  output logic       out_a_d,
  output logic       out_flag_done,
  output logic [7:0] out_dato_leido,
  output logic [7:0] out_addr_leida,
  output logic       out_dato_valido
);
  typedef enum logic [3:0] {
    IDLE, A_SETUP, A_STROBE, A_HOLD, GAP, D_SETUP, D_STROBE, D_HOLD, DONE, RECOVER
  } state_t;
  state_t state;
  logic [7:0] cnt, addr_q, data_q, lim;
  logic wr_q, last, a_ph, d_ph;
  always_comb begin
    lim  = (state == GAP) ? 8'(T_GAP) : 8'(T_PHASE);
    last = (cnt == lim - 8'd1) || (state inside {DONE, RECOVER});
    a_ph = state inside {A_SETUP, A_STROBE, A_HOLD};
    d_ph = state inside {D_SETUP, D_STROBE, D_HOLD};
  end
  // Outputs are registered from the current state, so every strobe lags its state by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      cnt             <= 8'd0;
      addr_q          <= 8'd0;
      data_q          <= 8'd0;
      wr_q            <= 1'b0;
      out_ad_bus      <= 8'd0;
      out_ad_oe       <= 1'b0;
      out_cs_n        <= 1'b1;
      out_rd_n        <= 1'b1;
      out_wr_n        <= 1'b1;
      out_a_d         <= 1'b1;
      out_flag_done   <= 1'b0;
      out_dato_leido  <= 8'd0;
      out_addr_leida  <= 8'd0;
      out_dato_valido <= 1'b0;
    end else begin
      out_cs_n        <= !(a_ph || d_ph);
      out_a_d         <= !a_ph;
      out_ad_oe       <= a_ph || (d_ph && wr_q);
      out_ad_bus      <= a_ph ? addr_q : (d_ph && wr_q) ? data_q : 8'd0;
      out_wr_n        <= !(state == A_STROBE || (state == D_STROBE && wr_q));
      out_rd_n        <= !(state == D_STROBE && !wr_q);
      out_flag_done   <= state == DONE;
      out_dato_valido <= state == DONE && !wr_q;
      if (state == IDLE) begin
        cnt <= 8'd0;
        if (in_en_funcion_rtc) begin
          addr_q <= in_addr_ram_rtc;
          wr_q   <= in_funcion_w_r;
          data_q <= in_flag_inicio ? in_dato_inicio : in_dato_escritura;
          state  <= A_SETUP;
        end
      end else if (last) begin
        cnt   <= 8'd0;
        state <= (state == RECOVER) ? IDLE : state_t'(state + 4'd1);
        if (state == D_STROBE && !wr_q) begin
          out_dato_leido <= in_ad_bus;
          out_addr_leida <= addr_q;
        end
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_rtc_bus_driver.sv
// tb_rtc_bus_driver: randomized scoreboard bench; monitor decodes bus activity and matches it to queued requests.
module tb_rtc_bus_driver;
  logic clk = 1'b0, reset = 1'b0, en = 1'b0, w_r = 1'b0, inicio = 1'b0;
  logic [7:0] addr = 8'd0, di = 8'd0, de = 8'd0, bus_in = 8'd0;
  logic [7:0] ad_bus, dato_leido, addr_leida;
  logic ad_oe, cs_n, rd_n, wr_n, a_d, flag_done, dato_valido;

  rtc_bus_driver dut (
    .clk(clk), .reset(reset), .in_en_funcion_rtc(en), .in_funcion_w_r(w_r),
    .in_flag_inicio(inicio), .in_addr_ram_rtc(addr), .in_dato_inicio(di),
    .in_dato_escritura(de), .in_ad_bus(bus_in), .out_ad_bus(ad_bus), .out_ad_oe(ad_oe),
    .out_cs_n(cs_n), .out_rd_n(rd_n), .out_wr_n(wr_n), .out_a_d(a_d),
    .out_flag_done(flag_done), .out_dato_leido(dato_leido), .out_addr_leida(addr_leida),
    .out_dato_valido(dato_valido)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] addr, wdata, rdata;
    logic wr;
    int cyc;
  } exp_t;
  exp_t q[$];
  exp_t me;
  int checks = 0, errors = 0;
  int aw = 0, dw = 0, rd = 0;
  logic [7:0] oa = 8'd0, od = 8'd0;
  logic prev_done = 1'b0;

  task automatic chk(input string n, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", n, act, req, cyc);
    end
  endtask

  // Monitor: reconstructs each transaction from strobe activity, then checks it against the queue on done.
  always @(negedge clk) begin
    if (!reset) begin
      aw = 0; dw = 0; rd = 0; prev_done = 1'b0;
    end else begin
      if (!cs_n && !wr_n) begin
        if (!a_d) begin aw++; oa = ad_bus; end
        else begin dw++; od = ad_bus; end
        chk("wr_oe", int'(ad_oe), 1);
      end
      if (!cs_n && !rd_n) begin
        rd++;
        chk("rd_oe", int'(ad_oe), 0);
        chk("rd_a_d", int'(a_d), 1);
      end
      if (dato_valido) chk("valid_with_done", int'(flag_done), 1);
      if (flag_done) begin
        chk("done_single", int'(prev_done), 0);
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
        end else begin
          me = q.pop_front();
          chk("done_cycle", cyc, me.cyc);
          chk("valido", int'(dato_valido), int'(!me.wr));
          chk("addr_strobe_len", aw, 4);
          chk("addr_value", int'(oa), int'(me.addr));
          if (me.wr) begin
            chk("data_strobe_len", dw, 4);
            chk("data_value", int'(od), int'(me.wdata));
            chk("no_rd", rd, 0);
          end else begin
            chk("rd_strobe_len", rd, 4);
            chk("no_data_wr", dw, 0);
            chk("dato_leido", int'(dato_leido), int'(me.rdata));
            chk("addr_leida", int'(addr_leida), int'(me.addr));
          end
        end
        aw = 0; dw = 0; rd = 0;
      end
      prev_done = flag_done;
    end
  end

  // Issue one request; returns at the last negedge before the next possible sampling edge.
  task automatic issue(input logic iw, input logic ii, input logic [7:0] ia, input logic [7:0] idi,
                       input logic [7:0] ide, input logic [7:0] ird, input int drop, input bit nowait);
    int k;
    exp_t e;
    if (!nowait) @(negedge clk);
    en = 1'b1; w_r = iw; inicio = ii; addr = ia; di = idi; de = ide; bus_in = ird;
    @(posedge clk);
    #1 k = cyc;
    e.addr = ia; e.wr = iw; e.wdata = ii ? idi : ide; e.rdata = ird; e.cyc = k + 27;
    q.push_back(e);
    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      if (i == drop) en = 1'b0;
      if (i == 1) begin
        w_r = 1'($urandom); inicio = 1'($urandom); addr = 8'($urandom);
        di = 8'($urandom); de = 8'($urandom);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bit hold;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", int'(cs_n), 1);
    chk("rst_rd_n", int'(rd_n), 1);
    chk("rst_wr_n", int'(wr_n), 1);
    chk("rst_a_d", int'(a_d), 1);
    chk("rst_oe", int'(ad_oe), 0);
    chk("rst_bus", int'(ad_bus), 0);
    chk("rst_done", int'(flag_done), 0);
    chk("rst_valido", int'(dato_valido), 0);
    chk("rst_leido", int'(dato_leido), 0);
    chk("rst_addr_leida", int'(addr_leida), 0);
    en = 1'b1; w_r = 1'b1; inicio = 1'b1; addr = 8'h02; di = 8'h10;
    @(negedge clk);
    reset = 1'b1;
    issue(1'b1, 1'b1, 8'h02, 8'h10, 8'h33, 8'h00, 0, 1'b1);
    issue(1'b0, 1'b0, 8'h21, 8'h00, 8'h00, 8'h45, 0, 1'b0);
    issue(1'b1, 1'b0, 8'h00, 8'h55, 8'hA7, 8'h00, 5, 1'b0);
    issue(1'b0, 1'b1, 8'h21, 8'h00, 8'h00, 8'h81, -1, 1'b0);
    issue(1'b0, 1'b1, 8'h22, 8'h00, 8'h00, 8'h82, -1, 1'b0);
    issue(1'b0, 1'b1, 8'h23, 8'h00, 8'h00, 8'h83, 0, 1'b0);
    for (int n = 0; n < 16; n++) begin
      hold = (n < 15) && ($urandom_range(0, 2) == 0);
      issue(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
            hold ? -1 : int'($urandom_range(0, 27)), 1'b0);
      if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    // Read aborted by reset in its data strobe: no done may follow.
    @(negedge clk);
    en = 1'b1; w_r = 1'b0; addr = 8'h3C; bus_in = 8'h99;
    @(posedge clk);
    #1 en = 1'b0;
    repeat (20) @(posedge clk);
    #3 chk("pre_rst_rd_n", int'(rd_n), 0);
    reset = 1'b0;
    #1;
    chk("abort_cs_n", int'(cs_n), 1);
    chk("abort_rd_n", int'(rd_n), 1);
    chk("abort_wr_n", int'(wr_n), 1);
    chk("abort_oe", int'(ad_oe), 0);
    chk("abort_done", int'(flag_done), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    issue(1'b1, 1'b0, 8'h5A, 8'h11, 8'hC3, 8'h00, 0, 1'b1);
    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
